mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 34 +++
 rtl/mem_wb_stage_data_memory.sv | 101 ++++++++++
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 tb/tb_mem_wb_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB pipeline slice:
//   - DMEM_AW_DEFAULT : default data-memory word-address width
//   - jr_kind_e       : encodings of the Mcntrljr jump-kind field
//   - mem_size_e      : encodings of the MSize access-size field
//   - jump_target()   : builds the pseudo-direct jump address
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DMEM_AW_DEFAULT = 10;

    typedef enum logic [1:0] {
        JR_NONE = 2'b00,
        JR_REG  = 2'b01,
        JR_IMM  = 2'b10,
        JR_RSVD = 2'b11   // behaves as JR_NONE
    } jr_kind_e;

    typedef enum logic [1:0] {
        SIZE_WORD     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_BYTE     = 2'b10,
        SIZE_WORD_ALT = 2'b11 // behaves as SIZE_WORD
    } mem_size_e;

    // Pseudo-direct jump: keep the 256 MB region of PC+4, splice in the
    // 26-bit index and word-align it.
    function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                                input logic [25:0] index);
        return {region, index, 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// 2^AW x 32-bit data memory: synchronous write, asynchronous read.
// A read and a write to the same word in one cycle returns the old contents,
// because the read is combinational from the array before the edge.
//
// Configuration macro: DMEM_BYTE_EN
//   undefined : word-only accesses (byte_off / size ports absent)
//   defined   : byte/half lane writes and sign-extended sub-word reads
//
// Ports:
//   clk       in   clock, writes on rising edge
//   we        in   write enable (already qualified with reset by the caller)
//   re        in   read enable; rdata is 0 when low
//   word_idx  in   AW-bit word index
//   byte_off  in   2-bit byte offset          (DMEM_BYTE_EN only)
//   size      in   2-bit access size          (DMEM_BYTE_EN only)
//   wdata     in   32-bit store data (sub-word data in the low bits)
//   rdata     out  32-bit read data
// -----------------------------------------------------------------------------
module data_memory
    import mem_wb_stage_pkg::*;
#(
    parameter int AW = DMEM_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] word_idx,
`ifdef DMEM_BYTE_EN
    input  logic [1:0]    byte_off,
    input  logic [1:0]    size,
`endif
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] word_q;

    assign word_q = mem[word_idx];

`ifdef DMEM_BYTE_EN
    logic [3:0]  lane_en;
    logic [31:0] lane_data;
    logic [15:0] half_q;
    logic [7:0]  byte_q;

    // Replicate sub-word store data across all lanes; lane_en picks the
    // lanes that actually get written.
    always_comb begin
        lane_en   = 4'b1111;
        lane_data = wdata;
        case (mem_size_e'(size))
            SIZE_HALF: begin
                lane_en   = byte_off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            SIZE_BYTE: begin
                lane_en   = 4'b0001 << byte_off;
                lane_data = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset branch; memory contents survive reset, and
    // a reset loop over the whole array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    // Misaligned half accesses use byte_off[1] only.
    assign half_q = byte_off[1] ? word_q[31:16] : word_q[15:0];
    assign byte_q = word_q[8*byte_off +: 8];

    always_comb begin
        rdata = 32'd0;
        if (re) begin
            case (mem_size_e'(size))
                SIZE_HALF: rdata = {{16{half_q[15]}}, half_q};
                SIZE_BYTE: rdata = {{24{byte_q[7]}}, byte_q};
                default:   rdata = word_q;
            endcase
        end
    end
`else
    // NOTE: the array has no reset branch; memory contents survive reset, and
    // a reset loop over the whole array would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) mem[word_idx] <= wdata;
    end

    assign rdata = re ? word_q : 32'd0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// MEM stage plus MEM/WB pipeline register: PC-redirect logic, data memory
// access, writeback-data mux and the registered writeback outputs.
//
// Configuration macro: DMEM_BYTE_EN (adds MSize and sub-word accesses).
//
// Ports:
//   Clk           in   clock
//   Rst           in   synchronous active-high reset
//   Mbranch       in   conditional branch
//   Mmemread      in   load
//   Mmemtoreg     in   writeback selects memory data
//   Mmemwrite     in   store
//   Mregwrite     in   register write request
//   Mcntrljalr    in   jalr link (write PC+4)
//   Mcntrljald    in   jal link (write PC+4)
//   Mcntrljr[1:0] in   jump kind (none / register / immediate)
//   M250Inst[25:0]in   jump index
//   MRD1[31:0]    in   register jump target
//   MPCAddResult  in   PC+4
//   MAddResult    in   branch target
//   MAluZero      in   branch condition
//   MAluResult    in   memory byte address or ALU value
//   MRD2[31:0]    in   store data
//   MRegDst[4:0]  in   destination register
//   MSize[1:0]    in   access size (DMEM_BYTE_EN only)
//   PCSrc         out  redirect fetch / flush younger stages (combinational)
//   PCNext[31:0]  out  redirect target (combinational)
//   WBregwrite    out  registered write enable
//   WBWriteData   out  registered write data
//   WBRegDst      out  registered destination
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Mbranch,
    input  logic        Mmemread,
    input  logic        Mmemtoreg,
    input  logic        Mmemwrite,
    input  logic        Mregwrite,
    input  logic        Mcntrljalr,
    input  logic        Mcntrljald,
    input  logic [1:0]  Mcntrljr,
    input  logic [25:0] M250Inst,
    input  logic [31:0] MRD1,
    input  logic [31:0] MPCAddResult,
    input  logic [31:0] MAddResult,
    input  logic        MAluZero,
    input  logic [31:0] MAluResult,
    input  logic [31:0] MRD2,
    input  logic [4:0]  MRegDst,
`ifdef DMEM_BYTE_EN
    input  logic [1:0]  MSize,
`endif
    output logic        PCSrc,
    output logic [31:0] PCNext,
    output logic        WBregwrite,
    output logic [31:0] WBWriteData,
    output logic [4:0]  WBRegDst
);

    logic        store_en;
    logic [31:0] mem_rdata;
    logic [31:0] wb_data;

    // ---------------- PC redirect (jr beats jump-immediate beats branch) ----
    // NOTE: every output is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        PCSrc  = 1'b0;
        PCNext = 32'd0;
        case (jr_kind_e'(Mcntrljr))
            JR_REG: begin
                PCSrc  = 1'b1;
                PCNext = MRD1;
            end
            JR_IMM: begin
                PCSrc  = 1'b1;
                PCNext = jump_target(MPCAddResult[31:28], M250Inst);
            end
            default: begin
                if (Mbranch && MAluZero) begin
                    PCSrc  = 1'b1;
                    PCNext = MAddResult;
                end
            end
        endcase
    end

    // ---------------- Data memory ------------------------------------------
    // Upper address bits are dropped, so addresses wrap within the array.
    assign store_en = Mmemwrite & ~Rst;

    data_memory #(.AW(DMEM_AW)) u_dmem (
        .clk      (Clk),
        .we       (store_en),
        .re       (Mmemread),
        .word_idx (MAluResult[DMEM_AW+1:2]),
`ifdef DMEM_BYTE_EN
        .byte_off (MAluResult[1:0]),
        .size     (MSize),
`endif
        .wdata    (MRD2),
        .rdata    (mem_rdata)
    );

    // ---------------- Writeback mux ----------------------------------------
    always_comb begin
        wb_data = MAluResult;
        if (Mcntrljalr || Mcntrljald) wb_data = MPCAddResult;
        else if (Mmemtoreg)           wb_data = mem_rdata;
    end

    // ---------------- MEM/WB register --------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            WBregwrite  <= 1'b0;
            WBWriteData <= 32'd0;
            WBRegDst    <= 5'd0;
        end else begin
            // Register 0 is hard-wired; never request a write to it.
            WBregwrite  <= Mregwrite & (MRegDst != 5'd0);
            WBWriteData <= wb_data;
            WBRegDst    <= MRegDst;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Directed self-checking bench for mem_wb_stage. Build with DMEM_BYTE_EN
// defined to also exercise the sub-word access path.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        Clk;
    logic        Rst;
    logic        Mbranch, Mmemread, Mmemtoreg, Mmemwrite, Mregwrite;
    logic        Mcntrljalr, Mcntrljald;
    logic [1:0]  Mcntrljr;
    logic [25:0] M250Inst;
    logic [31:0] MRD1, MPCAddResult, MAddResult, MAluResult, MRD2;
    logic        MAluZero;
    logic [4:0]  MRegDst;
`ifdef DMEM_BYTE_EN
    logic [1:0]  MSize;
`endif
    logic        PCSrc;
    logic [31:0] PCNext;
    logic        WBregwrite;
    logic [31:0] WBWriteData;
    logic [4:0]  WBRegDst;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Mbranch      (Mbranch),
        .Mmemread     (Mmemread),
        .Mmemtoreg    (Mmemtoreg),
        .Mmemwrite    (Mmemwrite),
        .Mregwrite    (Mregwrite),
        .Mcntrljalr   (Mcntrljalr),
        .Mcntrljald   (Mcntrljald),
        .Mcntrljr     (Mcntrljr),
        .M250Inst     (M250Inst),
        .MRD1         (MRD1),
        .MPCAddResult (MPCAddResult),
        .MAddResult   (MAddResult),
        .MAluZero     (MAluZero),
        .MAluResult   (MAluResult),
        .MRD2         (MRD2),
        .MRegDst      (MRegDst),
`ifdef DMEM_BYTE_EN
        .MSize        (MSize),
`endif
        .PCSrc        (PCSrc),
        .PCNext       (PCNext),
        .WBregwrite   (WBregwrite),
        .WBWriteData  (WBWriteData),
        .WBRegDst     (WBRegDst)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Mbranch = 0; Mmemread = 0; Mmemtoreg = 0; Mmemwrite = 0; Mregwrite = 0;
        Mcntrljalr = 0; Mcntrljald = 0; Mcntrljr = 2'b00; M250Inst = '0;
        MRD1 = '0; MPCAddResult = '0; MAddResult = '0; MAluZero = 0;
        MAluResult = '0; MRD2 = '0; MRegDst = '0;
`ifdef DMEM_BYTE_EN
        MSize = 2'b00;
`endif
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        idle();
        Mmemwrite = 1; MAluResult = addr; MRD2 = data;
        tick();
    endtask

    // Load into register rd; WB outputs are checked after the edge.
    task automatic load(input logic [31:0] addr, input logic [4:0] rd);
        idle();
        Mmemread = 1; Mmemtoreg = 1; Mregwrite = 1; MAluResult = addr; MRegDst = rd;
        tick();
    endtask

    initial begin
        idle();
        Rst = 1;
        tick();
        check("reset_regwrite", {31'd0, WBregwrite}, 32'd0);
        check("reset_wdata",    WBWriteData,         32'd0);
        check("reset_regdst",   {27'd0, WBRegDst},   32'd0);

        // Seed a known word, then hold reset 2 cycles with writes requested.
        Rst = 0;
        store(32'h40, 32'h1111_1111);
        idle();
        Rst = 1; Mregwrite = 1; Mmemwrite = 1; MAluResult = 32'h40;
        MRD2 = 32'h2222_2222; MRegDst = 5'd9;
        tick();
        check("rst_c1_regwrite", {31'd0, WBregwrite}, 32'd0);
        check("rst_c1_wdata",    WBWriteData,         32'd0);
        tick();
        check("rst_c2_regwrite", {31'd0, WBregwrite}, 32'd0);
        check("rst_c2_regdst",   {27'd0, WBRegDst},   32'd0);
        Rst = 0;
        load(32'h40, 5'd9);
        check("rst_no_store", WBWriteData, 32'h1111_1111);

        // Store then load through memtoreg.
        store(32'h40, 32'hDEAD_BEEF);
        load(32'h40, 5'd8);
        check("ld_wdata",    WBWriteData,         32'hDEAD_BEEF);
        check("ld_regdst",   {27'd0, WBRegDst},   32'd8);
        check("ld_regwrite", {31'd0, WBregwrite}, 32'd1);

        // Address wrap: 0x1040 maps to the same word as 0x40.
        load(32'h0000_1040, 5'd4);
        check("ld_wrap", WBWriteData, 32'hDEAD_BEEF);

        // Simultaneous read/write of the same word: old data, write lands.
        idle();
        Mmemread = 1; Mmemtoreg = 1; Mregwrite = 1; Mmemwrite = 1;
        MAluResult = 32'h40; MRD2 = 32'h1234_5678; MRegDst = 5'd5;
        tick();
        check("rw_old_data", WBWriteData, 32'hDEAD_BEEF);
        load(32'h40, 5'd5);
        check("rw_new_data", WBWriteData, 32'h1234_5678);

        // Word store ignores the low address bits.
        store(32'h83, 32'hA5A5_A5A5);
        load(32'h80, 5'd6);
        check("st_unaligned", WBWriteData, 32'hA5A5_A5A5);

        // Memtoreg with memread low reads as zero.
        idle();
        Mmemtoreg = 1; Mregwrite = 1; MAluResult = 32'h80; MRegDst = 5'd6;
        tick();
        check("noread_zero", WBWriteData, 32'd0);

        // ALU writeback path.
        idle();
        Mregwrite = 1; MAluResult = 32'hCAFE_F00D; MRegDst = 5'd3;
        tick();
        check("alu_wdata",  WBWriteData,       32'hCAFE_F00D);
        check("alu_regdst", {27'd0, WBRegDst}, 32'd3);

        // Branch redirect.
        idle();
        Mbranch = 1; MAluZero = 1; MAddResult = 32'h200;
        #1;
        check("br_taken_src",  {31'd0, PCSrc}, 32'd1);
        check("br_taken_next", PCNext,         32'h200);
        MAluZero = 0;
        #1;
        check("br_not_src",  {31'd0, PCSrc}, 32'd0);
        check("br_not_next", PCNext,         32'd0);

        // jr beats branch; jump-immediate target; jr=11 falls to branch.
        MAluZero = 1; Mcntrljr = 2'b01; MRD1 = 32'h3FC;
        #1;
        check("jr_src",  {31'd0, PCSrc}, 32'd1);
        check("jr_next", PCNext,         32'h3FC);
        Mcntrljr = 2'b10; M250Inst = 26'd2047; MPCAddResult = 32'h1000;
        #1;
        check("j_next", PCNext, 32'h1FFC);
        MPCAddResult = 32'hA000_1000;
        #1;
        check("j_region", PCNext, 32'hA000_1FFC);
        Mcntrljr = 2'b11;
        #1;
        check("jr11_branch", PCNext, 32'h200);

        // Redirect remains combinational during reset.
        Rst = 1; Mcntrljr = 2'b01;
        #1;
        check("rst_redirect", PCNext, 32'h3FC);
        tick();
        Rst = 0;

        // jal link writes PC+4 (beats memtoreg); rd=0 suppresses write.
        idle();
        Mcntrljald = 1; Mregwrite = 1; Mmemtoreg = 1; Mmemread = 1;
        MAluResult = 32'h40; MPCAddResult = 32'd1024; MRegDst = 5'd31;
        tick();
        check("jal_wdata",    WBWriteData,         32'd1024);
        check("jal_regdst",   {27'd0, WBRegDst},   32'd31);
        check("jal_regwrite", {31'd0, WBregwrite}, 32'd1);
        MRegDst = 5'd0;
        tick();
        check("rd0_regwrite", {31'd0, WBregwrite}, 32'd0);
        idle();
        Mcntrljalr = 1; Mregwrite = 1; MPCAddResult = 32'h44; MRegDst = 5'd1;
        tick();
        check("jalr_wdata", WBWriteData, 32'h44);

`ifdef DMEM_BYTE_EN
        store(32'h40, 32'h0000_0000);
        idle();
        Mmemwrite = 1; MSize = 2'b10; MAluResult = 32'h43; MRD2 = 32'h0000_0080;
        tick();
        idle();
        Mmemread = 1; Mmemtoreg = 1; Mregwrite = 1; MRegDst = 5'd2;
        MSize = 2'b10; MAluResult = 32'h43;
        tick();
        check("lb_sext", WBWriteData, 32'hFFFF_FF80);
        load(32'h40, 5'd2);
        check("lw_after_sb", WBWriteData, 32'h8000_0000);
        idle();
        Mmemwrite = 1; MSize = 2'b01; MAluResult = 32'h40; MRD2 = 32'hFFFF_8001;
        tick();
        load(32'h40, 5'd2);
        check("lw_after_sh", WBWriteData, 32'h8000_8001);
        idle();
        Mmemread = 1; Mmemtoreg = 1; Mregwrite = 1; MRegDst = 5'd2;
        MSize = 2'b01; MAluResult = 32'h43;
        tick();
        check("lh_misalign", WBWriteData, 32'hFFFF_8000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
